// File: rtl/sync_edge_capture_if.sv
// Event-queue handshake between sync_edge_capture (master) and its consumer (slave).
// Head type, valid and occupancy flow out; the consumer's ready flows back.
interface sync_edge_capture_if #(
  parameter int DEPTH = 4
) ();
  logic                   evt_valid_o;
  logic                   evt_ready_i;
  logic                   evt_type_o;
  logic [$clog2(DEPTH):0] evt_count_o;

  modport master (
    output evt_valid_o,
    output evt_type_o,
    output evt_count_o,
    input  evt_ready_i
  );

  modport slave (
    input  evt_valid_o,
    input  evt_type_o,
    input  evt_count_o,
    output evt_ready_i
  );
endinterface

// File: rtl/sync_edge_capture.sv
// Debounce filter on a pre-synchronized level, with edge pulses and a small event FIFO.
// Level changes after FILTER_CYCLES consecutive differing samples; events drop when the FIFO is full.
module sync_edge_capture #(
  parameter int   FILTER_CYCLES = 3,
  parameter int   DEPTH         = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                 clk_dst,
  input  logic                 rst_dst,
  input  logic                 din_sync,
  input  logic                 en_i,
  input  logic                 clr_i,
  output logic                 level_o,
  output logic                 rise_pulse_o,
  output logic                 fall_pulse_o,
  output logic                 overflow_o,
  sync_edge_capture_if.master  evt
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [7:0]     LP_LAST = 8'(FILTER_CYCLES - 1);
  localparam logic [AW:0]    LP_FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } state_t;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;

  logic [DEPTH-1:0]  r_mem;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_overflow;

  logic              w_differ;
  logic              w_accept;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;

  assign w_differ = (din_sync != r_level);

  // A change is accepted on the sample that completes the qualification run.
  assign w_accept = en_i && w_differ &&
                    (((r_state == ST_STABLE) && (FILTER_CYCLES == 1)) ||
                     ((r_state == ST_QUAL) && (r_cnt == LP_LAST)));

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_FULL);
  assign w_pop   = !w_empty && evt.evt_ready_i;
  assign w_push  = w_accept && (!w_full || w_pop) && !clr_i && !rst_dst;

  always_ff @(posedge clk_dst) begin
    if (rst_dst) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!en_i) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
      end else if (w_accept) begin
        r_level <= ~r_level;
        r_rise  <= ~r_level;
        r_fall  <= r_level;
        r_state <= ST_STABLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_STABLE: begin
            if (w_differ) begin
              r_state <= ST_QUAL;
              r_cnt   <= 8'd1;
            end
          end
          ST_QUAL: begin
            if (!w_differ) begin
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_dst) begin
    if (w_push) begin
      r_mem[r_wptr] <= ~r_level;
    end
  end

  always_ff @(posedge clk_dst) begin
    if (rst_dst || clr_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Simultaneous pop frees a slot, so a full queue only drops without one.
      if (w_accept && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign level_o         = r_level;
  assign rise_pulse_o    = r_rise;
  assign fall_pulse_o    = r_fall;
  assign overflow_o      = r_overflow;
  assign evt.evt_valid_o = !w_empty;
  assign evt.evt_type_o  = !w_empty && r_mem[r_rptr];
  assign evt.evt_count_o = r_count;

endmodule

// File: tb/tb_sync_edge_capture.sv
// Scoreboard bench for sync_edge_capture with FILTER_CYCLES=3, DEPTH=4, RESET_LEVEL=0.
module tb_sync_edge_capture;

  localparam int DEPTH = 4;

  logic clk_dst = 1'b0;
  logic rst_dst;
  logic din_sync;
  logic en_i;
  logic clr_i;
  logic level_o;
  logic rise_pulse_o;
  logic fall_pulse_o;
  logic overflow_o;

  sync_edge_capture_if #(.DEPTH(DEPTH)) evt_if ();

  sync_edge_capture #(
    .FILTER_CYCLES (3),
    .DEPTH         (DEPTH),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk_dst      (clk_dst),
    .rst_dst      (rst_dst),
    .din_sync     (din_sync),
    .en_i         (en_i),
    .clr_i        (clr_i),
    .level_o      (level_o),
    .rise_pulse_o (rise_pulse_o),
    .fall_pulse_o (fall_pulse_o),
    .overflow_o   (overflow_o),
    .evt          (evt_if.master)
  );

  always #5 clk_dst = ~clk_dst;

  int   total = 0;
  int   bad   = 0;
  bit   sb[$];
  bit   exp_ovf = 1'b0;
  logic exp_lvl = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dst);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_lvl"},   level_o, 0);
    chk({tag, "_rise"},  rise_pulse_o, 0);
    chk({tag, "_fall"},  fall_pulse_o, 0);
    chk({tag, "_vld"},   evt_if.evt_valid_o, 0);
    chk({tag, "_type"},  evt_if.evt_type_o, 0);
    chk({tag, "_cnt"},   evt_if.evt_count_o, 0);
    chk({tag, "_ovf"},   overflow_o, 0);
  endtask

  task automatic do_reset();
    rst_dst = 1'b1;
    tick();
    rst_dst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_lvl = 1'b0;
  endtask

  // Hold din at v for three edges with ready low; the third edge must accept.
  task automatic apply_level(input bit v);
    din_sync = v;
    tick();
    tick();
    chk("qual_hold", level_o, exp_lvl);
    tick();
    exp_lvl = v;
    if (sb.size() < DEPTH) sb.push_back(v);
    else exp_ovf = 1'b1;
    chk("acc_lvl",  level_o, v);
    chk("acc_rise", rise_pulse_o, v);
    chk("acc_fall", fall_pulse_o, !v);
    chk("acc_cnt",  evt_if.evt_count_o, sb.size());
    chk("acc_ovf",  overflow_o, exp_ovf);
    tick();
    chk("pulse_end", rise_pulse_o | fall_pulse_o, 0);
  endtask

  task automatic drain();
    bit e;
    for (int i = 0; i < 3 * DEPTH && evt_if.evt_valid_o; i++) begin
      if (sb.size() == 0) begin
        chk("sb_underrun", 1, 0);
        break;
      end
      e = sb.pop_front();
      chk("pop_type", evt_if.evt_type_o, e);
      evt_if.evt_ready_i = 1'b1;
      tick();
      evt_if.evt_ready_i = 1'b0;
    end
    chk("drain_sb",  sb.size(), 0);
    chk("drain_cnt", evt_if.evt_count_o, 0);
    chk("drain_vld", evt_if.evt_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit e;
    rst_dst  = 1'b1;
    din_sync = 1'b0;
    en_i     = 1'b1;
    clr_i    = 1'b0;
    evt_if.evt_ready_i = 1'b0;
    tick();
    do_reset();
    chk_reset_state("rst");

    // Single rise, then a two-cycle glitch that must be rejected.
    apply_level(1'b1);
    chk("rise_vld",  evt_if.evt_valid_o, 1);
    chk("rise_type", evt_if.evt_type_o, 1);
    din_sync = 1'b0;
    tick();
    tick();
    din_sync = 1'b1;
    tick();
    tick();
    chk("glitch_lvl", level_o, 1);
    chk("glitch_cnt", evt_if.evt_count_o, 1);
    chk("glitch_pls", rise_pulse_o | fall_pulse_o, 0);
    drain();

    // Ready while empty is ignored.
    evt_if.evt_ready_i = 1'b1;
    tick();
    evt_if.evt_ready_i = 1'b0;
    chk("empty_rdy_cnt", evt_if.evt_count_o, 0);

    // Enable low discards a partial qualification.
    do_reset();
    din_sync = 1'b1;
    tick();
    tick();
    en_i = 1'b0;
    tick();
    tick();
    en_i = 1'b1;
    tick();
    tick();
    chk("en_discard_lvl", level_o, 0);
    chk("en_discard_cnt", evt_if.evt_count_o, 0);
    tick();
    exp_lvl = 1'b1;
    sb.push_back(1'b1);
    chk("en_resume_lvl",  level_o, 1);
    chk("en_resume_rise", rise_pulse_o, 1);
    tick();
    drain();

    // Five changes without a consumer: fifth is dropped.
    do_reset();
    apply_level(1'b1);
    apply_level(1'b0);
    apply_level(1'b1);
    apply_level(1'b0);
    apply_level(1'b1);
    chk("ovf_full_cnt", evt_if.evt_count_o, 4);
    chk("ovf_flag",     overflow_o, 1);
    drain();
    chk("ovf_sticky", overflow_o, 1);

    // Clear with three queued and overflow set.
    apply_level(1'b0);
    apply_level(1'b1);
    apply_level(1'b0);
    chk("pre_clr_cnt", evt_if.evt_count_o, 3);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    chk("clr_cnt", evt_if.evt_count_o, 0);
    chk("clr_ovf", overflow_o, 0);
    chk("clr_vld", evt_if.evt_valid_o, 0);
    chk("clr_lvl", level_o, 0);

    // Full queue with a pop on the accepting edge: nothing dropped.
    apply_level(1'b1);
    apply_level(1'b0);
    apply_level(1'b1);
    apply_level(1'b0);
    din_sync = 1'b1;
    tick();
    tick();
    e = sb.pop_front();
    chk("fullpop_head", evt_if.evt_type_o, e);
    sb.push_back(1'b1);
    evt_if.evt_ready_i = 1'b1;
    tick();
    evt_if.evt_ready_i = 1'b0;
    exp_lvl = 1'b1;
    chk("fullpop_cnt",  evt_if.evt_count_o, 4);
    chk("fullpop_ovf",  overflow_o, 0);
    chk("fullpop_lvl",  level_o, 1);
    chk("fullpop_rise", rise_pulse_o, 1);
    tick();
    drain();

    // Reset in the middle of qualification with level high.
    din_sync = 1'b0;
    tick();
    tick();
    chk("midq_lvl", level_o, 1);
    rst_dst = 1'b1;
    tick();
    rst_dst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_lvl = 1'b0;
    chk_reset_state("midq_rst");
    tick();
    chk("midq_after_pls", rise_pulse_o | fall_pulse_o, 0);
    chk("midq_after_lvl", level_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
